dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Byte-addressed data memory with a valid/ready request/response handshake and fixed access latency.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned halfword and word accesses as errors.
module dmem_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_access,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MISALIGN_CHK = 1'b1;
`else
   localparam bit MISALIGN_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   logic [3:0]              cnt;

   logic                    cap_write;
   logic [ADDR_WIDTH-1:0]   cap_addr;
   logic [31:0]             cap_wdata;
   logic [2:0]              cap_access;

   logic [7:0]              mem [DEPTH];

   logic                    cur_write;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [31:0]             cur_wdata;
   logic [2:0]              cur_access;
   logic                    cur_err;
   logic [3:0]              lanes;
   logic [31:0]             rd_word;
   logic [31:0]             rdata_next;
   logic                    enter_resp;
   logic                    commit;
   logic                    unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

   function automatic logic access_err(input logic [2:0] acc, input logic [1:0] lo);
      logic bad;
      bad = (acc == 3'b011) || (acc == 3'b110) || (acc == 3'b111);
      if (MISALIGN_CHK) begin
         if ((acc[1:0] == 2'b01) && lo[0])         bad = 1'b1;
         if ((acc[1:0] == 2'b10) && (lo != 2'b00)) bad = 1'b1;
      end
      return bad;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [2:0] acc);
      case (acc[1:0])
         2'b00:   return 4'b0001;
         2'b01:   return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] acc, input logic [31:0] word);
      logic signed [31:0] ext;
      case (acc)
         3'b000:  ext = 32'(signed'(word[7:0]));
         3'b001:  ext = 32'(signed'(word[15:0]));
         3'b010:  ext = signed'(word);
         3'b100:  ext = signed'({24'd0, word[7:0]});
         3'b101:  ext = signed'({16'd0, word[15:0]});
         default: ext = '0;
      endcase
      return unsigned'(ext);
   endfunction

   // With LATENCY=1 the transaction resolves on the accept edge, so use the live request fields
   always_comb begin
      if (state == IDLE) begin
         cur_write  = req_write;
         cur_addr   = req_addr[ADDR_WIDTH-1:0];
         cur_wdata  = req_wdata;
         cur_access = req_access;
      end else begin
         cur_write  = cap_write;
         cur_addr   = cap_addr;
         cur_wdata  = cap_wdata;
         cur_access = cap_access;
      end
      enter_resp = 1'b0;
      if (state == IDLE)      enter_resp = req_valid && (LATENCY == 1);
      else if (state == WAIT) enter_resp = (cnt == 4'd0);
      cur_err    = access_err(cur_access, cur_addr[1:0]);
      lanes      = lane_mask(cur_access);
      commit     = enter_resp && !rst && cur_write && !cur_err;
      rd_word    = {mem[cur_addr + ADDR_WIDTH'(3)], mem[cur_addr + ADDR_WIDTH'(2)],
                    mem[cur_addr + ADDR_WIDTH'(1)], mem[cur_addr]};
      rdata_next = (cur_write || cur_err) ? 32'd0 : load_extend(cur_access, rd_word);
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         cap_write  <= req_write;
         cap_addr   <= req_addr[ADDR_WIDTH-1:0];
         cap_wdata  <= req_wdata;
         cap_access <= req_access;
      end
   end

   // Lanes wrap modulo the storage size through the ADDR_WIDTH-bit sum
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (lanes[i]) mem[cur_addr + ADDR_WIDTH'(i)] <= cur_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  if (enter_resp) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rdata_next;
                     rsp_err   <= cur_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (enter_resp) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rdata_next;
                  rsp_err   <= cur_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'd0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
